// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle adder/subtractor for the processor datapath.
// Each cycle adds one CHUNK-bit slice of the latched operands through a
// registered carry, so wide operands only need a short carry chain per cycle.
// The block uses a start/done handshake. It supports an accumulate mode, where
// the previous result is reused as operand A, and it produces ALU status flags.
// The result and the flags change only when an operation completes.
module addsub_seq #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic             acc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   // Number of slices per operation and the width of the slice counter.
   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   // Reject illegal parameter combinations at elaboration time.
   generate
      if (WIDTH < 2) begin : g_bad_width
         $error("addsub_seq: WIDTH must be at least 2");
      end
      if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
         $error("addsub_seq: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // Operands latched at start. B is already inverted for subtraction.
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   // The carry between slices. It starts at 1 for subtraction.
   logic             r_carry;
   // Index of the slice added on the next RUN edge.
   logic [CW-1:0]    r_cnt;
   // The result is assembled here slice by slice. It is not visible on s.
   logic [WIDTH-1:0] r_res;

   // Architectural outputs. These are written only at completion or reset.
   logic [WIDTH-1:0] r_s;
   logic             r_co;
   logic             r_ovf;
   logic             r_zero;
   logic             r_neg;
   logic             r_done;

   // Slice arithmetic for the current RUN cycle.
   int               w_base;
   logic [CHUNK-1:0] w_opa_chunk;
   logic [CHUNK-1:0] w_opb_chunk;
   logic [CHUNK:0]   w_chunk_sum;
   logic [WIDTH-1:0] w_res_next;
   logic             w_last;
   logic             w_ovf;

   // Add the current slice, then merge it into the partially built result.
   always_comb begin
      // NOTE: every signal gets a default before any conditional logic, so no
      // path can leave a value unassigned and infer a latch.
      w_base      = int'(r_cnt) * CHUNK;
      w_opa_chunk = r_opa[w_base +: CHUNK];
      w_opb_chunk = r_opb[w_base +: CHUNK];
      w_chunk_sum = {1'b0, w_opa_chunk} + {1'b0, w_opb_chunk}
                  + {{CHUNK{1'b0}}, r_carry};
      w_res_next  = r_res;
      w_res_next[w_base +: CHUNK] = w_chunk_sum[CHUNK-1:0];
      w_last      = (r_cnt == LAST);
      // Signed overflow: the operand signs agree, but the result sign differs.
      w_ovf       = (r_opa[WIDTH-1] == r_opb[WIDTH-1])
                 && (w_res_next[WIDTH-1] != r_opa[WIDTH-1]);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments, so every register
      // in the design samples the values that existed before the clock edge.
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic. A start is accepted only in IDLE. RUN lasts N cycles.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start)  w_state_next = S_RUN;
         S_RUN:   if (w_last) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Datapath: latch operands at start, add one slice per RUN cycle, and
   // publish the result and flags on the final slice.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every register is cleared by reset, the working registers
      // included, so an aborted operation leaves no stale partial state behind.
      if (!rst_n) begin
         r_opa   <= '0;
         r_opb   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_res   <= '0;
         r_s     <= '0;
         r_co    <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
         r_neg   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  // In accumulate mode, take operand A from the published
                  // result. When start arrives in the done cycle, that result
                  // has just been written.
                  r_opa   <= acc ? r_s : a;
                  r_opb   <= sub ? ~b : b;
                  r_carry <= sub;
                  r_cnt   <= '0;
                  r_res   <= '0;
               end
            end
            S_RUN: begin
               r_res   <= w_res_next;
               r_carry <= w_chunk_sum[CHUNK];
               r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
               if (w_last) begin
                  r_s    <= w_res_next;
                  r_co   <= w_chunk_sum[CHUNK];
                  r_ovf  <= w_ovf;
                  r_zero <= (w_res_next == '0);
                  r_neg  <= w_res_next[WIDTH-1];
                  r_done <= 1'b1;
               end
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = r_done;
   assign s    = r_s;
   assign co   = r_co;
   assign ovf  = r_ovf;
   assign zero = r_zero;
   assign neg  = r_neg;

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised multi-cycle adder/subtractor for the processor datapath; successor to the fixed 3-bit ripple add/sub.
- Processes CHUNK bits per clock through a registered carry, so wide operands close timing on a short carry chain.
- Adds a start/done handshake, an accumulate mode and status flags (carry/borrow, signed overflow, zero, negative) for the ALU/flag register.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CHUNK, 2, bits processed per cycle; WIDTH must be a multiple of CHUNK (elaboration error otherwise). N = WIDTH/CHUNK.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- sub  in  1  0=A+B, 1=A-B (two's complement: B inverted, carry-in=1)
- acc  in  1  1=use current s register as operand A (a ignored)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- s  out  WIDTH  result, held until next completion
- co  out  1  final carry-out (sub: 1=no borrow, i.e. A>=B unsigned)
- ovf  out  1  signed overflow
- zero  out  1  s==0
- neg  out  1  s[WIDTH-1]

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, co, ovf, zero, neg = 0; s = 0; internal operand, carry and chunk-count registers = 0. Reset mid-operation aborts it: no done pulse, outputs cleared.
- States: IDLE, RUN.
- IDLE, start=1 at edge E0:
  - latch opA = acc ? s : a; opB = sub ? ~b : b; carry = sub; cnt = 0.
  - record opA/opB MSBs for overflow; busy=1; go to RUN.
- RUN, edge Ek (k=1..N):
  - add chunk k-1: bits [(k-1)*CHUNK +: CHUNK] of opA + opB + carry.
  - write sum bits into the result shift/holding register; carry <= chunk carry-out; cnt++.
- Final edge EN (cnt = N-1 on entry):
  - s <= full result; co <= final carry.
  - ovf <= (opA_msb == opB_msb) && (result_msb != opA_msb); zero, neg from the new result.
  - done <= 1; busy <= 0; state -> IDLE.
- Latency: done high in the cycle after EN, i.e. N cycles after start is sampled. N=1 when CHUNK=WIDTH.
- done clears on the next edge unless another operation completes there (not possible for N>=1 from a new start).
- start while busy=1: ignored; operands/inputs are not resampled.
- start in the done cycle: accepted (state is IDLE); done drops at that edge. acc in that cycle uses the just-written s.
- Inputs a, b, sub, acc are sampled only at E0; changes during RUN have no effect.
- s and the flags change only at completion edges or reset; they never show partial results.
- Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH=8, CHUNK=2: start, sub=0, a=0x3C, b=0x05 -> done exactly 4 cycles later; s=0x41, co=0, ovf=0, zero=0, neg=0; busy high for 4 cycles.
- sub=1, a=0x05, b=0x07 -> s=0xFE, co=0 (borrow), neg=1, ovf=0. Then sub=1, a=0x80, b=0x01 -> s=0x7F, co=1, ovf=1.
- a=0x7F+b=0x01 -> s=0x80, ovf=1, neg=1. Then a=0xFF+b=0x01 -> s=0x00, co=1, zero=1, ovf=0.
- After s=0x41: acc=1, a=0xAA, b=0x10, sub=0 -> s=0x51. Pulse start again at cycle 2 of RUN with different operands -> ignored; only one done.
- Start a=0x3C, b=0x05; drop rst_n for one cycle at RUN cycle 2 -> busy=0, done=0, s=0 immediately; no done pulse within 10 following cycles.
- CHUNK=8: done 1 cycle after start. Issue a new start in each done cycle for 4 ops -> 4 back-to-back done pulses every 2 cycles with correct results.
